// File: rtl/chimera_cluster_pwr_seq_pkg.sv
// Shared types and default timing for the external-cluster power sequencer.
package chimera_cluster_pwr_seq_pkg;

    localparam int unsigned ExtClusters     = 5;
    localparam int unsigned CmdIdxW         = $clog2(ExtClusters);
    localparam int unsigned ClkSettleCycles = 4;
    localparam int unsigned RstHoldCycles   = 8;
    localparam int unsigned IdleTimeout     = 256;

    typedef enum logic [2:0] {
        StIdle,
        StClkOn,
        StRstRel,
        StIsoWait,
        StRstAssert,
        StClkOff
    } pwr_seq_state_e;

    typedef struct packed {
        logic [CmdIdxW-1:0] idx;
        logic               on;
    } pwr_seq_cmd_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/chimera_cluster_pwr_seq_if.sv
// Command handshake from the register slave into the power sequencer.
interface chimera_cluster_pwr_seq_if #(
    parameter int unsigned IdxW = 3
);
    logic            valid;
    logic            ready;
    logic [IdxW-1:0] cluster;
    logic            on;

    modport master (output valid, output cluster, output on, input ready);
    modport slave  (input valid, input cluster, input on, output ready);
endinterface

// File: rtl/chimera_pwr_delay_cnt.sv
// Loadable down-counter that stops at zero; shared by every timed sequencer state.
module chimera_pwr_delay_cnt #(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/chimera_cluster_pwr_seq.sv
// Serialised clock-enable / reset / AXI-isolation sequencer for the external clusters.
module chimera_cluster_pwr_seq #(
    parameter int unsigned NumClusters     = chimera_cluster_pwr_seq_pkg::ExtClusters,
    parameter int unsigned ClkSettleCycles = chimera_cluster_pwr_seq_pkg::ClkSettleCycles,
    parameter int unsigned RstHoldCycles   = chimera_cluster_pwr_seq_pkg::RstHoldCycles,
    parameter int unsigned IdleTimeout     = chimera_cluster_pwr_seq_pkg::IdleTimeout
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    chimera_cluster_pwr_seq_if.slave   cmd_if,
    input  logic [NumClusters-1:0]     cluster_idle_i,
    output logic [NumClusters-1:0]     clk_en_o,
    output logic [NumClusters-1:0]     cluster_rst_o,
    output logic [NumClusters-1:0]     isolate_o,
    output logic [NumClusters-1:0]     on_o,
    output logic                       busy_o,
    output logic                       err_o
);
    import chimera_cluster_pwr_seq_pkg::*;

    localparam int unsigned CntW = $clog2(max3(ClkSettleCycles, RstHoldCycles, IdleTimeout) + 1);

    pwr_seq_state_e         state_q;
    pwr_seq_cmd_t           cmd_q;
    logic [NumClusters-1:0] clk_en_q, rst_q, iso_q, on_q;
    logic                   ready_q, err_q;

    logic            accept, bad_idx, cur_on, start_up, start_dn, sel_idle, iso_done;
    logic            cnt_load, cnt_zero;
    logic [CntW-1:0] cnt_val;

    always_comb begin
        accept   = ready_q && cmd_if.valid;
        bad_idx  = 32'(cmd_if.cluster) >= NumClusters;
        cur_on   = bad_idx ? 1'b0 : on_q[cmd_if.cluster];
        start_up = accept && !bad_idx && cmd_if.on && !cur_on;
        start_dn = accept && !bad_idx && !cmd_if.on && cur_on;
        sel_idle = cluster_idle_i[cmd_q.idx];
        iso_done = (state_q == StIsoWait) && (sel_idle || cnt_zero);

        // Each timed state reloads the counter on the edge that enters it.
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (start_up) begin
            cnt_load = 1'b1;
            cnt_val  = CntW'(ClkSettleCycles - 1);
        end else if (start_dn) begin
            cnt_load = 1'b1;
            cnt_val  = CntW'(IdleTimeout - 1);
        end else if (((state_q == StClkOn) && cnt_zero) || iso_done) begin
            cnt_load = 1'b1;
            cnt_val  = CntW'(RstHoldCycles - 1);
        end
    end

    chimera_pwr_delay_cnt #(
        .Width (CntW)
    ) u_delay_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            clk_en_q <= '0;
            rst_q    <= '1;
            iso_q    <= '1;
            on_q     <= '0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept && bad_idx) begin
                        err_q <= 1'b1;
                    end else if (start_up) begin
                        cmd_q                    <= '{idx: cmd_if.cluster, on: 1'b1};
                        clk_en_q[cmd_if.cluster] <= 1'b1;
                        ready_q                  <= 1'b0;
                        state_q                  <= StClkOn;
                    end else if (start_dn) begin
                        cmd_q                 <= '{idx: cmd_if.cluster, on: 1'b0};
                        iso_q[cmd_if.cluster] <= 1'b1;
                        on_q[cmd_if.cluster]  <= 1'b0;
                        ready_q               <= 1'b0;
                        state_q               <= StIsoWait;
                    end
                end
                StClkOn: begin
                    if (cnt_zero) begin
                        rst_q[cmd_q.idx] <= 1'b0;
                        state_q          <= StRstRel;
                    end
                end
                StRstRel: begin
                    if (cnt_zero) begin
                        iso_q[cmd_q.idx] <= ~cmd_q.on;
                        on_q[cmd_q.idx]  <= cmd_q.on;
                        ready_q          <= 1'b1;
                        state_q          <= StIdle;
                    end
                end
                StIsoWait: begin
                    // A timeout is flagged but the cluster is still taken down.
                    if (iso_done) begin
                        err_q            <= ~sel_idle;
                        rst_q[cmd_q.idx] <= 1'b1;
                        state_q          <= StRstAssert;
                    end
                end
                StRstAssert: begin
                    if (cnt_zero) begin
                        clk_en_q[cmd_q.idx] <= 1'b0;
                        state_q             <= StClkOff;
                    end
                end
                StClkOff: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_if.ready  = ready_q;
    assign busy_o        = ~ready_q;
    assign err_o         = err_q;
    assign clk_en_o      = clk_en_q;
    assign cluster_rst_o = rst_q;
    assign isolate_o     = iso_q;
    assign on_o          = on_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Bench for chimera_cluster_pwr_seq: vector table, timing sequences and random traffic vs a model.
module tb_chimera_cluster_pwr_seq;

    localparam int unsigned N = 5;
    localparam int unsigned C = 4;
    localparam int unsigned R = 8;
    localparam int unsigned I = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] idle = '1;
    logic [N-1:0] clk_en, crst, iso, on;
    logic         busy, err;

    chimera_cluster_pwr_seq_if #(.IdxW(3)) cmd_if ();

    chimera_cluster_pwr_seq #(
        .NumClusters     (N),
        .ClkSettleCycles (C),
        .RstHoldCycles   (R),
        .IdleTimeout     (I)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cmd_if         (cmd_if),
        .cluster_idle_i (idle),
        .clk_en_o       (clk_en),
        .cluster_rst_o  (crst),
        .isolate_o      (iso),
        .on_o           (on),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: scheduled output changes keyed by absolute edge number.
    typedef struct {
        int at;
        int kind;
        int idx;
    } ev_t;
    localparam int EvRstRel = 0, EvUpDone = 1, EvClkOff = 2, EvReady = 3;

    ev_t          evq[$];
    logic [N-1:0] m_clk = '0, m_rst = '1, m_iso = '1, m_on = '0;
    logic         m_rdy = 1'b1, m_err = 1'b0;
    int           edge_n = 0;
    bit           dn_pend = 0;
    int           dn_t = 0, dn_idx = 0;

    task automatic model_edge();
        bit rdy_before;
        int idx;
        rdy_before = m_rdy;
        edge_n++;
        if (rst) begin
            m_clk = '0; m_rst = '1; m_iso = '1; m_on = '0; m_rdy = 1'b1; m_err = 1'b0;
            evq.delete();
            dn_pend = 0;
            return;
        end
        m_err = 1'b0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].at == edge_n) begin
                case (evq[i].kind)
                    EvRstRel: m_rst[evq[i].idx] = 1'b0;
                    EvUpDone: begin
                        m_iso[evq[i].idx] = 1'b0;
                        m_on[evq[i].idx]  = 1'b1;
                        m_rdy = 1'b1;
                    end
                    EvClkOff: m_clk[evq[i].idx] = 1'b0;
                    default:  m_rdy = 1'b1;
                endcase
                evq.delete(i);
            end
        end
        if (dn_pend && edge_n > dn_t) begin
            if (idle[dn_idx] || (edge_n - dn_t) == int'(I)) begin
                m_err = !idle[dn_idx];
                m_rst[dn_idx] = 1'b1;
                evq.push_back('{edge_n + R, EvClkOff, dn_idx});
                evq.push_back('{edge_n + R + 1, EvReady, dn_idx});
                dn_pend = 0;
            end
        end
        if (rdy_before && cmd_if.valid) begin
            idx = int'(cmd_if.cluster);
            if (idx >= int'(N)) begin
                m_err = 1'b1;
            end else if (cmd_if.on && !m_on[idx]) begin
                m_rdy = 1'b0;
                m_clk[idx] = 1'b1;
                evq.push_back('{edge_n + C, EvRstRel, idx});
                evq.push_back('{edge_n + C + R, EvUpDone, idx});
            end else if (!cmd_if.on && m_on[idx]) begin
                m_rdy = 1'b0;
                m_iso[idx] = 1'b1;
                m_on[idx]  = 1'b0;
                dn_pend = 1;
                dn_t = edge_n;
                dn_idx = idx;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (err === 1'b1) err_cnt++;
        chk("model", {9'b0, clk_en, crst, iso, on, cmd_if.ready, busy, err},
            {9'b0, m_clk, m_rst, m_iso, m_on, m_rdy, ~m_rdy, m_err});
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (cmd_if.ready !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("ready_within_budget", {31'b0, cmd_if.ready}, 32'd1);
    endtask

    task automatic send(input logic [2:0] cl, input logic o);
        cmd_if.valid = 1'b1;
        cmd_if.cluster = cl;
        cmd_if.on = o;
        step();
        cmd_if.valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]   cluster;
        logic         on;
        logic [N-1:0] exp_clk, exp_rst, exp_iso, exp_on;
        logic         exp_err;
    } vec_t;
    vec_t vecs[10];

    initial begin
        logic idle_mode;
        vecs[0] = '{3'd2, 1'b1, 5'h04, 5'h1B, 5'h1B, 5'h04, 1'b0};
        vecs[1] = '{3'd2, 1'b1, 5'h04, 5'h1B, 5'h1B, 5'h04, 1'b0};
        vecs[2] = '{3'd7, 1'b1, 5'h04, 5'h1B, 5'h1B, 5'h04, 1'b1};
        vecs[3] = '{3'd0, 1'b1, 5'h05, 5'h1A, 5'h1A, 5'h05, 1'b0};
        vecs[4] = '{3'd4, 1'b1, 5'h15, 5'h0A, 5'h0A, 5'h15, 1'b0};
        vecs[5] = '{3'd2, 1'b0, 5'h11, 5'h0E, 5'h0E, 5'h11, 1'b0};
        vecs[6] = '{3'd3, 1'b0, 5'h11, 5'h0E, 5'h0E, 5'h11, 1'b0};
        vecs[7] = '{3'd5, 1'b1, 5'h11, 5'h0E, 5'h0E, 5'h11, 1'b1};
        vecs[8] = '{3'd0, 1'b0, 5'h10, 5'h0F, 5'h0F, 5'h10, 1'b0};
        vecs[9] = '{3'd4, 1'b0, 5'h00, 5'h1F, 5'h1F, 5'h00, 1'b0};

        cmd_if.valid = 1'b0;
        cmd_if.cluster = '0;
        cmd_if.on = 1'b0;

        // Reset, then idle
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        chk("rst_clk_en", clk_en, 5'h00);
        chk("rst_cluster_rst", crst, 5'h1F);
        chk("rst_isolate", iso, 5'h1F);
        chk("rst_on", on, 5'h00);
        chk("rst_ready", cmd_if.ready, 1'b1);

        // Power-up cluster 2: exact edge timing
        idle = '1;
        send(3'd2, 1'b1);
        chk("up_clk_en_t1", clk_en, 5'h04);
        chk("up_rst_held_t1", crst, 5'h1F);
        chk("up_busy_t1", cmd_if.ready, 1'b0);
        repeat (C - 1) step();
        chk("up_rst_held_t4", crst[2], 1'b1);
        step();
        chk("up_rst_rel_t5", crst, 5'h1B);
        repeat (R - 1) step();
        chk("up_not_on_t12", on[2], 1'b0);
        step();
        chk("up_on_t13", on, 5'h04);
        chk("up_iso_t13", iso, 5'h1B);
        chk("up_ready_t13", cmd_if.ready, 1'b1);

        // Power-down cluster 2, idle low for 20 cycles
        idle = '0;
        err_cnt = 0;
        send(3'd2, 1'b0);
        chk("dn_iso_t1", iso, 5'h1F);
        chk("dn_on_t1", on, 5'h00);
        repeat (20) step();
        chk("dn_rst_wait", crst[2], 1'b0);
        idle = 5'h04;
        step();
        chk("dn_rst_assert", crst, 5'h1F);
        chk("dn_clk_still_on", clk_en[2], 1'b1);
        repeat (R - 1) step();
        chk("dn_clk_hold", clk_en[2], 1'b1);
        step();
        chk("dn_clk_off", clk_en, 5'h00);
        chk("dn_busy_clkoff", cmd_if.ready, 1'b0);
        step();
        chk("dn_ready", cmd_if.ready, 1'b1);
        chk("dn_no_err", err_cnt, 0);

        // Table of whole commands
        idle = '1;
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].cluster, vecs[i].on);
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            wait_ready(400);
            chk($sformatf("vec%0d_clk_en", i), clk_en, vecs[i].exp_clk);
            chk($sformatf("vec%0d_rst", i), crst, vecs[i].exp_rst);
            chk($sformatf("vec%0d_iso", i), iso, vecs[i].exp_iso);
            chk($sformatf("vec%0d_on", i), on, vecs[i].exp_on);
        end

        // Idle stuck low: timeout pulse, sequence still completes
        send(3'd2, 1'b1);
        wait_ready(400);
        idle = '0;
        err_cnt = 0;
        send(3'd2, 1'b0);
        repeat (I - 1) step();
        chk("to_no_err_early", err_cnt, 0);
        step();
        chk("to_err_pulse", err, 1'b1);
        chk("to_rst_assert", crst[2], 1'b1);
        wait_ready(400);
        chk("to_single_pulse", err_cnt, 1);
        chk("to_clk_off", clk_en, 5'h00);

        // Reset mid power-up with valid held high
        idle = '1;
        cmd_if.valid = 1'b1;
        cmd_if.cluster = 3'd1;
        cmd_if.on = 1'b1;
        step();
        cmd_if.cluster = 3'd3;
        step();
        chk("mid_ready_low", cmd_if.ready, 1'b0);
        step();
        chk("mid_no_second_cmd", clk_en, 5'h02);
        rst = 1'b1;
        cmd_if.valid = 1'b0;
        step();
        chk("mid_rst_clk_en", clk_en, 5'h00);
        chk("mid_rst_rst", crst, 5'h1F);
        chk("mid_rst_ready", cmd_if.ready, 1'b1);
        rst = 1'b0;
        step();
        chk("mid_after_clk_en", clk_en, 5'h00);

        // Random traffic against the model
        idle_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) idle_mode = ~idle_mode;
            idle = idle_mode ? 5'($urandom) : 5'h00;
            cmd_if.valid = ($urandom_range(0, 3) == 0);
            cmd_if.cluster = 3'($urandom_range(0, 7));
            cmd_if.on = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        cmd_if.valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
